// File: rtl/mem_accum.sv
// mem_accum: read-modify-write accumulator that sweeps an internal simple-dual-port RAM.
// Define MEM_ACCUM_SAT_EN to saturate on add overflow instead of wrapping.
module mem_accum #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DUMP,
        S_FIN
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              last_reg, last_next;
    logic [ADDR_W-1:0] addr_d_reg;
    logic [DATA_W-1:0] data_d_reg;
    logic              wr_pend_reg;
    logic              dout_valid_reg;
    logic              overflow_reg, overflow_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_en;
    logic              wr_en;
    logic              handshake;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] acc_value;
    logic [DATA_W:0]   sum;

    // last_reg marks that the final address has been issued; the pass then drains one cycle.
    assign in_ready  = (state_reg == S_ACCUM) && !last_reg;
    assign handshake = in_ready && in_valid;
    assign rd_en     = handshake || ((state_reg == S_DUMP) && !last_reg);

    assign sum = {1'b0, rd_data_reg} + {1'b0, data_d_reg};
`ifdef MEM_ACCUM_SAT_EN
    assign acc_value = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
    assign acc_value = sum[DATA_W-1:0];
`endif

    assign wr_en   = (state_reg == S_CLEAR) || wr_pend_reg;
    assign wr_addr = (state_reg == S_CLEAR) ? addr_reg : addr_d_reg;
    assign wr_data = (state_reg == S_CLEAR) ? '0 : acc_value;

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        last_next     = last_reg;
        overflow_next = overflow_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next = '0;
                    last_next = 1'b0;
                    case (cmd)
                        2'b00:   state_next = S_CLEAR;
                        2'b01: begin
                            state_next    = S_ACCUM;
                            overflow_next = 1'b0;
                        end
                        2'b10:   state_next = S_DUMP;
                        default: state_next = S_FIN;
                    endcase
                end
            end
            S_CLEAR: begin
                if (addr_reg == ADDR_LAST) state_next = S_FIN;
                else                       addr_next  = addr_reg + 1'b1;
            end
            S_ACCUM: begin
                if (last_reg) begin
                    state_next = S_FIN;
                end else if (handshake) begin
                    if (addr_reg == ADDR_LAST) last_next = 1'b1;
                    else                       addr_next = addr_reg + 1'b1;
                end
            end
            S_DUMP: begin
                if (last_reg)                   state_next = S_FIN;
                else if (addr_reg == ADDR_LAST) last_next  = 1'b1;
                else                            addr_next  = addr_reg + 1'b1;
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (wr_pend_reg && sum[DATA_W]) overflow_next = 1'b1;
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            last_reg       <= 1'b0;
            addr_d_reg     <= '0;
            data_d_reg     <= '0;
            wr_pend_reg    <= 1'b0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            last_reg       <= last_next;
            overflow_reg   <= overflow_next;
            wr_pend_reg    <= handshake;
            dout_valid_reg <= (state_reg == S_DUMP) && !last_reg;
            if (handshake) begin
                addr_d_reg <= addr_reg;
                data_d_reg <= in_data;
            end
        end
    end

    // RAM kept free of reset so it maps onto block RAM; reset only gates the controls above.
    always_ff @(posedge clka) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_reg <= mem[addr_reg];
    end

    assign dout       = dout_valid_reg ? rd_data_reg : '0;
    assign dout_valid = dout_valid_reg;
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_FIN);
    assign overflow   = overflow_reg;

endmodule

// File: doc/mem_accum.md
# mem_accum

Parametrised read-modify-write accumulator over an internal simple-dual-port RAM. An internal address counter sweeps the whole memory. Each pass either clears it, adds one input sample into each word, or streams the contents out. It sits between a sample source and downstream readout logic, for example as a histogram or frame-integration buffer.

## Interface
- DATA_W, 16: word and sample width (unsigned).
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W; ADDR_W >= 1.
- clka  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- cmd  in  2  command: 00 CLEAR, 01 ACCUM, 10 DUMP, 11 no-op.
- in_valid  in  1  sample valid.
- in_data  in  DATA_W  sample.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- dout  out  DATA_W  dump word.
- dout_valid  out  1  dout qualifier.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at the end of a pass.
- overflow  out  1  sticky add-overflow flag for the current or last ACCUM pass.

## Operation
- States: IDLE, CLEAR, ACCUM, DUMP, FIN.
- IDLE with start=1:
  - Go to CLEAR, ACCUM or DUMP according to cmd; addr <= 0.
  - For cmd=11, go to FIN.
  - overflow is cleared only by a start with cmd=01.
- start while not in IDLE is ignored.
- CLEAR:
  - Writes 0 to mem[addr] and increments addr, one word per cycle.
  - After the write at DEPTH-1, go to FIN.
- ACCUM:
  - in_ready=1. On each handshake, issue a read of mem[addr] and register in_data; addr increments.
  - One cycle later, write mem[addr_d] <= mem[addr_d] + in_data_d.
  - Gaps in in_valid are allowed; addr holds.
  - After the handshake at DEPTH-1, drop in_ready, then go to FIN after the final write.
  - Back-to-back handshakes always target different addresses (addr_d != addr), so no read-after-write hazard exists.
- DUMP:
  - Issues reads for addresses 0..DEPTH-1 on consecutive cycles.
  - dout/dout_valid follow each read by 1 cycle.
  - There is no back-pressure.
  - Go to FIN after the last dout_valid.
- FIN: done=1 for one cycle, then IDLE.
- Arithmetic: DATA_W+1-bit unsigned sum. A carry sets overflow, which holds until the next ACCUM start or rst. Write-back value depends on the configuration below.
- The internal RAM has one write port, one read port, and synchronous read with 1-cycle latency. Its contents are not affected by rst and are undefined until a CLEAR pass.

## Timing
- Reset values: in_ready=0, dout=0, dout_valid=0, busy=0, done=0, overflow=0; state IDLE; addr 0.
- rst mid-pass aborts immediately:
  - No further writes occur; a pending ACCUM write is dropped.
  - The RAM keeps whatever has been written so far.
- Numbering for a pass: start sampled at edge 0; busy=1 from cycle 1.
- CLEAR: writes occur in cycles 1..DEPTH; done is high in cycle DEPTH+1; busy=0 in cycle DEPTH+2.
- ACCUM with in_valid held high:
  - Handshakes occur in cycles 1..DEPTH.
  - Writes occur in cycles 2..DEPTH+1.
  - done is high in cycle DEPTH+2.
- DUMP: dout_valid is high in cycles 2..DEPTH+1 with dout = mem[0..DEPTH-1]; done is high in cycle DEPTH+2.
- The no-op command (cmd=11) produces done in cycle 1.
- Address wrap: addr is an ADDR_W-bit counter. Pass termination is decoded from addr == DEPTH-1 at the final operation; addr never wraps inside a pass.

## Configuration
- MEM_ACCUM_SAT_EN defined: on carry, the written value is {DATA_W{1'b1}} (saturate); overflow is still set.
- MEM_ACCUM_SAT_EN undefined: the written value is the low DATA_W bits of the sum (wrap); overflow is set.

## Test plan
All scenarios use ADDR_W=3 (DEPTH=8) and DATA_W=16.

- CLEAR then DUMP -> 8 dout_valid beats, all 0x0000; done in cycle 10 of the DUMP pass.
- CLEAR, ACCUM with in_data=1..8, ACCUM again with the same data, DUMP -> dout = 2,4,…,16; overflow=0.
- ACCUM with in_valid toggling every other cycle -> exactly 8 handshakes; in_ready drops after the 8th; DUMP shows the correct per-address sums.
- Word preset to 0xFFF0, accumulate 0x0020 -> overflow=1. DUMP shows 0xFFFF with MEM_ACCUM_SAT_EN, 0x0010 without it.
- Assert rst in cycle 4 of an ACCUM pass -> all outputs 0 next cycle. A following DUMP shows addresses 0..1 updated and 2..7 unchanged (the cycle-4 write of address 2 is dropped).
- start pulsed during DUMP, and cmd=11 from IDLE -> the DUMP proceeds unaffected; the no-op gives a single done pulse with no RAM access.
